// File: rtl/dm_access_unit_if.sv
// Bundle of the MEM-stage request port, the data-memory RAM port and the response port.
// The master side is the pipeline plus RAM core; the slave side is dm_access_unit.
// Pure wiring: it adds no latency and no flow-control behaviour of its own.
interface dm_access_unit_if #(
  parameter int ADDR_WIDTH = 13
);
  // Request from the MEM stage
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_write;
  logic [1:0]            req_type;
  logic                  req_sign;
  logic [31:0]           req_addr;
  logic [31:0]           req_wdata;
  // RAM core port
  logic [3:0]            ram_we;
  logic [ADDR_WIDTH-3:0] ram_addr;
  logic [31:0]           ram_wdata;
  logic [31:0]           ram_rdata;
  // Response to the MEM stage
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [31:0]           rsp_rdata;
  logic                  rsp_write;
  logic                  rsp_err;

  modport master (
    output req_valid, req_write, req_type, req_sign, req_addr, req_wdata,
    input  req_ready,
    input  ram_we, ram_addr, ram_wdata,
    output ram_rdata,
    input  rsp_valid, rsp_rdata, rsp_write, rsp_err,
    output rsp_ready
  );

  modport slave (
    input  req_valid, req_write, req_type, req_sign, req_addr, req_wdata,
    output req_ready,
    output ram_we, ram_addr, ram_wdata,
    input  ram_rdata,
    output rsp_valid, rsp_rdata, rsp_write, rsp_err,
    input  rsp_ready
  );
endinterface

// File: rtl/dm_access_unit.sv
// Load/store front-end to the data-memory RAM: alignment/range check, byte lanes, load extension.
// Latency: store/error response 1 cycle after accept, load response 2 cycles after accept.
// Backpressure: one request in flight; the response is held in RESP until rsp_ready is high.
module dm_access_unit #(
  parameter int ADDR_WIDTH = 13
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  dm_access_unit_if.slave   bus
);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;

  state_t                state_q;
  logic [ADDR_WIDTH-3:0] addr_q;
  logic [1:0]            type_q;
  logic                  sign_q;
  logic [1:0]            off_q;
  logic                  rsp_valid_q;
  logic [31:0]           rsp_rdata_q;
  logic                  rsp_write_q;
  logic                  rsp_err_q;

  logic        accept;
  logic        req_err;
  logic [3:0]  lane_be;
  logic [31:0] load_val;
  logic [7:0]  load_byte;
  logic [15:0] load_half;

  // Reset gates req_ready so nothing is accepted (or written) while held in reset.
  assign bus.req_ready = (state_q == ST_IDLE) && rst_ni;
  assign accept        = bus.req_ready && bus.req_valid;

  // Illegal type, misaligned word/half, or address beyond the DM window.
  assign req_err = (bus.req_type == 2'd3)
                || ((bus.req_type == 2'd0) && (bus.req_addr[1:0] != 2'b00))
                || ((bus.req_type == 2'd1) && bus.req_addr[0])
                || (bus.req_addr[31:ADDR_WIDTH] != '0);

  // Byte-enable pattern for the addressed lane(s).
  always_comb begin
    lane_be = 4'b0000;
    case (bus.req_type)
      2'd0:    lane_be = 4'b1111;
      2'd1:    lane_be = bus.req_addr[1] ? 4'b1100 : 4'b0011;
      2'd2:    lane_be = 4'b0001 << bus.req_addr[1:0];
      default: lane_be = 4'b0000;
    endcase
  end

  assign bus.ram_we    = (accept && bus.req_write && !req_err) ? lane_be : 4'b0000;
  assign bus.ram_wdata = bus.req_wdata << {bus.req_addr[1:0], 3'b000};
  // Captured address outside IDLE keeps the RAM output stable while WAIT samples it.
  assign bus.ram_addr  = (state_q == ST_IDLE) ? bus.req_addr[ADDR_WIDTH-1:2] : addr_q;

  assign load_byte = bus.ram_rdata[{off_q, 3'b000} +: 8];
  assign load_half = bus.ram_rdata[{off_q[1], 4'b0000} +: 16];

  // Lane select plus sign/zero extension of the RAM word for the captured load.
  always_comb begin
    load_val = bus.ram_rdata;
    case (type_q)
      2'd1:    load_val = {{16{sign_q & load_half[15]}}, load_half};
      2'd2:    load_val = {{24{sign_q & load_byte[7]}}, load_byte};
      default: load_val = bus.ram_rdata;
    endcase
  end

  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_write = rsp_write_q;
  assign bus.rsp_err   = rsp_err_q;

  // Request/response FSM with registered response outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      type_q      <= 2'd0;
      sign_q      <= 1'b0;
      off_q       <= 2'd0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'd0;
      rsp_write_q <= 1'b0;
      rsp_err_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            if (req_err || bus.req_write) begin
              // Errors and stores respond directly; the store was written this edge.
              rsp_err_q   <= req_err;
              rsp_write_q <= bus.req_write;
              rsp_rdata_q <= 32'd0;
              rsp_valid_q <= 1'b1;
              state_q     <= ST_RESP;
            end else begin
              addr_q  <= bus.req_addr[ADDR_WIDTH-1:2];
              type_q  <= bus.req_type;
              sign_q  <= bus.req_sign;
              off_q   <= bus.req_addr[1:0];
              state_q <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          rsp_rdata_q <= load_val;
          rsp_err_q   <= 1'b0;
          rsp_write_q <= 1'b0;
          rsp_valid_q <= 1'b1;
          state_q     <= ST_RESP;
        end
        ST_RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dm_access_unit.sv
// Directed bench for dm_access_unit with a behavioural one-cycle-latency byte-enable RAM.
module tb_dm_access_unit;
  localparam int AW = 13;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dm_access_unit_if #(.ADDR_WIDTH(AW)) bus ();

  dm_access_unit #(.ADDR_WIDTH(AW)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  // RAM model: synchronous read of the current address, per-byte writes.
  logic [31:0] mem [0:(1<<(AW-2))-1];
  initial begin
    for (int i = 0; i < (1 << (AW - 2)); i++) mem[i] = 32'd0;
    bus.ram_rdata = 32'd0;
  end
  always @(posedge clk) begin
    bus.ram_rdata <= mem[bus.ram_addr];
    for (int b = 0; b < 4; b++)
      if (bus.ram_we[b]) mem[bus.ram_addr][8*b +: 8] <= bus.ram_wdata[8*b +: 8];
  end

  typedef struct {
    logic        wr;
    logic [1:0]  ty;
    logic        sg;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  we;
    logic [31:0] ram_wd;
    logic [31:0] rdata;
    logic        err;
  } vec_t;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic wr, input logic [1:0] ty, input logic sg,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [3:0] we, input logic [31:0] ram_wd,
                              input logic [31:0] rdata, input logic err);
    vec_t v;
    v.wr = wr; v.ty = ty; v.sg = sg; v.addr = addr; v.wdata = wdata;
    v.we = we; v.ram_wd = ram_wd; v.rdata = rdata; v.err = err;
    return v;
  endfunction

  task automatic present(input vec_t v);
    bus.req_valid = 1'b1;
    bus.req_write = v.wr;
    bus.req_type  = v.ty;
    bus.req_sign  = v.sg;
    bus.req_addr  = v.addr;
    bus.req_wdata = v.wdata;
  endtask

  // Called 1 time unit after a rising edge with rsp_ready high.
  task automatic run_vec(input string tag, input vec_t v);
    int lat;
    logic [31:0] exp_addr;
    present(v);
    #1;
    exp_addr = {19'd0, v.addr[AW-1:2]};
    check({tag, ".req_ready"}, {31'd0, bus.req_ready}, 32'd1);
    check({tag, ".ram_we"}, {28'd0, bus.ram_we}, {28'd0, v.we});
    check({tag, ".ram_addr"}, {21'd0, bus.ram_addr}, exp_addr);
    if (v.we != 4'b0000) check({tag, ".ram_wdata"}, bus.ram_wdata, v.ram_wd);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    lat = 1;
    while (!bus.rsp_valid && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, ".latency"}, lat, (v.wr || v.err) ? 32'd1 : 32'd2);
    check({tag, ".rsp_rdata"}, bus.rsp_rdata, v.rdata);
    check({tag, ".rsp_err"}, {31'd0, bus.rsp_err}, {31'd0, v.err});
    check({tag, ".rsp_write"}, {31'd0, bus.rsp_write}, {31'd0, v.wr});
    @(posedge clk); #1;
    check({tag, ".rsp_valid_after"}, {31'd0, bus.rsp_valid}, 32'd0);
    check({tag, ".req_ready_after"}, {31'd0, bus.req_ready}, 32'd1);
  endtask

  vec_t vecs [17];

  initial begin
    // Store/load sequence; later entries depend on the RAM contents left by earlier ones.
    vecs[0]  = mk(1, 2'd0, 0, 32'h10,   32'hDEADBEEF, 4'b1111, 32'hDEADBEEF, 32'h0,        0); // sw
    vecs[1]  = mk(0, 2'd2, 1, 32'h13,   32'h0,        4'b0000, 32'h0,        32'hFFFFFFDE, 0); // lb
    vecs[2]  = mk(0, 2'd1, 0, 32'h12,   32'h0,        4'b0000, 32'h0,        32'h0000DEAD, 0); // lhu
    vecs[3]  = mk(0, 2'd2, 0, 32'h10,   32'h0,        4'b0000, 32'h0,        32'h000000EF, 0); // lbu
    vecs[4]  = mk(1, 2'd2, 0, 32'h11,   32'h00000055, 4'b0010, 32'h00005500, 32'h0,        0); // sb
    vecs[5]  = mk(0, 2'd0, 0, 32'h10,   32'h0,        4'b0000, 32'h0,        32'hDEAD55EF, 0); // lw
    vecs[6]  = mk(1, 2'd1, 0, 32'h13,   32'h1234,     4'b0000, 32'h0,        32'h0,        1); // sh misaligned
    vecs[7]  = mk(0, 2'd0, 0, 32'h12,   32'h0,        4'b0000, 32'h0,        32'h0,        1); // lw misaligned
    vecs[8]  = mk(0, 2'd0, 0, 32'h2000, 32'h0,        4'b0000, 32'h0,        32'h0,        1); // lw out of range
    vecs[9]  = mk(1, 2'd0, 0, 32'h2000, 32'hFFFFFFFF, 4'b0000, 32'h0,        32'h0,        1); // sw out of range
    vecs[10] = mk(0, 2'd3, 0, 32'h10,   32'h0,        4'b0000, 32'h0,        32'h0,        1); // illegal type
    vecs[11] = mk(0, 2'd1, 1, 32'h10,   32'h0,        4'b0000, 32'h0,        32'h000055EF, 0); // lh positive
    vecs[12] = mk(1, 2'd1, 0, 32'h16,   32'hAAAA8001, 4'b1100, 32'h80010000, 32'h0,        0); // sh upper
    vecs[13] = mk(0, 2'd1, 1, 32'h16,   32'h0,        4'b0000, 32'h0,        32'hFFFF8001, 0); // lh negative
    vecs[14] = mk(0, 2'd1, 0, 32'h16,   32'h0,        4'b0000, 32'h0,        32'h00008001, 0); // lhu
    vecs[15] = mk(0, 2'd2, 1, 32'h11,   32'h0,        4'b0000, 32'h0,        32'h00000055, 0); // lb positive
    vecs[16] = mk(0, 2'd0, 0, 32'h0,    32'h0,        4'b0000, 32'h0,        32'h0,        0); // word 0 untouched

    bus.rsp_ready = 1'b1;
    present(mk(1, 2'd0, 0, 32'h0, 32'hFFFFFFFF, 4'b0, 32'h0, 32'h0, 0));
    #2;
    check("reset.req_ready", {31'd0, bus.req_ready}, 32'd0);
    check("reset.ram_we", {28'd0, bus.ram_we}, 32'd0);
    check("reset.rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    check("reset.rsp_rdata", bus.rsp_rdata, 32'd0);
    check("reset.rsp_err", {31'd0, bus.rsp_err}, 32'd0);
    check("reset.rsp_write", {31'd0, bus.rsp_write}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 17; i++) run_vec($sformatf("vec%0d", i), vecs[i]);

    // Back-pressure: hold the load response for 5 cycles with a store waiting.
    bus.rsp_ready = 1'b0;
    present(mk(0, 2'd0, 0, 32'h10, 32'h0, 4'b0, 32'h0, 32'h0, 0));
    @(posedge clk); #1;
    present(mk(1, 2'd0, 0, 32'h20, 32'h12345678, 4'b0, 32'h0, 32'h0, 0));
    @(posedge clk); #1;
    for (int k = 0; k < 5; k++) begin
      check("bp.rsp_valid", {31'd0, bus.rsp_valid}, 32'd1);
      check("bp.rsp_rdata", bus.rsp_rdata, 32'hDEAD55EF);
      check("bp.rsp_err", {31'd0, bus.rsp_err}, 32'd0);
      check("bp.req_ready", {31'd0, bus.req_ready}, 32'd0);
      check("bp.ram_we", {28'd0, bus.ram_we}, 32'd0);
      @(posedge clk); #1;
    end
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    check("bp.release_req_ready", {31'd0, bus.req_ready}, 32'd1);
    check("bp.release_ram_we", {28'd0, bus.ram_we}, 32'hF);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    check("bp.store_rsp_valid", {31'd0, bus.rsp_valid}, 32'd1);
    check("bp.store_rsp_write", {31'd0, bus.rsp_write}, 32'd1);
    @(posedge clk); #1;
    run_vec("bp_lw", mk(0, 2'd0, 0, 32'h20, 32'h0, 4'b0, 32'h0, 32'h12345678, 0));

    // Reset during WAIT: load discarded, store presented during reset not written.
    present(mk(0, 2'd0, 0, 32'h10, 32'h0, 4'b0, 32'h0, 32'h0, 0));
    @(posedge clk); #1;
    present(mk(1, 2'd0, 0, 32'h24, 32'hCAFEF00D, 4'b0, 32'h0, 32'h0, 0));
    rst_n = 1'b0;
    #1;
    check("rst.rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    check("rst.req_ready", {31'd0, bus.req_ready}, 32'd0);
    check("rst.ram_we", {28'd0, bus.ram_we}, 32'd0);
    repeat (2) begin
      @(posedge clk); #1;
      check("rst.hold_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    end
    bus.req_valid = 1'b0;
    rst_n = 1'b1;
    #1;
    check("rst.release_req_ready", {31'd0, bus.req_ready}, 32'd1);
    repeat (3) begin
      @(posedge clk); #1;
      check("rst.no_rsp", {31'd0, bus.rsp_valid}, 32'd0);
    end
    run_vec("rst_lw_unwritten", mk(0, 2'd0, 0, 32'h24, 32'h0, 4'b0, 32'h0, 32'h0, 0));
    run_vec("rst_sb", mk(1, 2'd2, 0, 32'h27, 32'h000000A5, 4'b1000, 32'hA5000000, 32'h0, 0));
    run_vec("rst_lw", mk(0, 2'd0, 0, 32'h24, 32'h0, 4'b0, 32'h0, 32'hA5000000, 0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
